// File: rtl/bt_operand_loader_if.sv
// Operand-loader bus: trit entry controls in, committed/staged words out.
interface bt_operand_loader_if #(
    parameter int NTRITS = 4
);
    localparam int SW = $clog2(NTRITS + 1);

    logic [1:0]          trit_in;
    logic                trit_stb;
    logic                clr;
    logic [2*NTRITS-1:0] calc_word;
    logic                word_valid;
    logic [2*NTRITS-1:0] stage_word;
    logic [SW-1:0]       slot;
    logic                err;

    // Trit source / operator side.
    modport master (
        output trit_in, trit_stb, clr,
        input  calc_word, word_valid, stage_word, slot, err
    );

    // Loader side.
    modport slave (
        input  trit_in, trit_stb, clr,
        output calc_word, word_valid, stage_word, slot, err
    );
endinterface

// File: rtl/bt_operand_loader.sv
// Balanced-ternary operand loader: synchronizes a slow trit strobe, stages
// trits slot by slot and publishes the packed word only once complete.

// One staging slot. A write beats a wipe so a new entry can clear the
// stage and drop its first trit into slot 0 on the same edge.
module bt_operand_slot (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr,
    input  logic       wipe,
    input  logic [1:0] din,
    output logic [1:0] q,
    output logic [1:0] nxt
);
    // Next slot value: write, wipe to ternary zero, or hold.
    always_comb begin
        nxt = q;
        if (wr)
            nxt = din;
        else if (wipe)
            nxt = 2'b11;
    end

    // Slot register, resets to ternary zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= 2'b11;
        else
            q <= nxt;
    end
endmodule

module bt_operand_loader #(
    parameter int NTRITS      = 4,
    parameter int SYNC_STAGES = 2
) (
    input logic                 clk,
    input logic                 rst,
    bt_operand_loader_if.slave  bus
);
    localparam int SW = $clog2(NTRITS + 1);
    localparam logic [2*NTRITS-1:0] ZERO_WORD = {NTRITS{2'b11}};

    // stb_pipe[SYNC_STAGES-1:0] are the synchronizer, [SYNC_STAGES] is the
    // edge-detect delay flop.
    logic [SYNC_STAGES:0]          stb_pipe;
    logic [SYNC_STAGES-1:0][1:0]   trit_pipe;

    logic [NTRITS-1:0][1:0] stage_q;
    logic [NTRITS-1:0][1:0] stage_nxt;
    logic [NTRITS-1:0]      wr;
    logic [2*NTRITS-1:0]    calc_q;
    logic                   valid_q;
    logic [SW-1:0]          slot_q;
    logic                   err_q;

    logic [1:0] code;
    logic       accept;
    logic       legal;
    logic       illegal;
    logic       reentry;
    logic       last;
    logic       wipe;

    // Synchronize strobe and trit code; the trit is read from the same
    // depth as the strobe so it lines up with the accept pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stb_pipe  <= '0;
            trit_pipe <= '0;
        end else begin
            stb_pipe  <= {stb_pipe[SYNC_STAGES-1:0], bus.trit_stb};
            trit_pipe <= {trit_pipe[SYNC_STAGES-2:0], bus.trit_in};
        end
    end

    // clr overrides any coincident accept.
    assign code    = trit_pipe[SYNC_STAGES-1];
    assign accept  = stb_pipe[SYNC_STAGES-1] & ~stb_pipe[SYNC_STAGES] & ~bus.clr;
    assign legal   = accept & (code != 2'b00);
    assign illegal = accept & (code == 2'b00);
    assign reentry = valid_q & (slot_q == '0);
    assign last    = (slot_q == SW'(NTRITS - 1));
    assign wipe    = bus.clr | (legal & reentry);

    for (genvar k = 0; k < NTRITS; k++) begin : g_slot
        assign wr[k] = legal & (slot_q == SW'(k));
        bt_operand_slot u_slot (
            .clk  (clk),
            .rst  (rst),
            .wr   (wr[k]),
            .wipe (wipe),
            .din  (code),
            .q    (stage_q[k]),
            .nxt  (stage_nxt[k])
        );
    end

    // Slot pointer, commit of a completed entry, and sticky error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q  <= '0;
            calc_q  <= ZERO_WORD;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else if (bus.clr) begin
            slot_q <= '0;
            err_q  <= 1'b0;
        end else if (illegal) begin
            err_q <= 1'b1;
        end else if (legal) begin
            if (last) begin
                slot_q  <= '0;
                calc_q  <= stage_nxt;
                valid_q <= 1'b1;
            end else begin
                slot_q <= slot_q + SW'(1);
            end
        end
    end

    assign bus.stage_word = stage_q;
    assign bus.calc_word  = calc_q;
    assign bus.word_valid = valid_q;
    assign bus.slot       = slot_q;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_bt_operand_loader.sv
// Bench for bt_operand_loader: vector table, hand-timed corner cases and
// randomized strobes checked against a transaction-level model.
module tb_bt_operand_loader;
    localparam int N = 4;
    localparam int S = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    bt_operand_loader_if #(.NTRITS(N)) bus ();

    bt_operand_loader #(.NTRITS(N), .SYNC_STAGES(S)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit         do_clr;
        logic [1:0] code;
        int         eslot;
        logic [7:0] estage;
        logic [7:0] ecalc;
        bit         evalid;
        bit         eerr;
    } vec_t;

    vec_t tbl[$];

    // Reference model: whole-entry view of the loader.
    int   m_stage[N];
    int   m_slot;
    logic [7:0] m_calc;
    bit   m_valid;
    bit   m_err;

    function automatic logic [7:0] m_pack();
        logic [7:0] w;
        for (int k = 0; k < N; k++) w[2*k +: 2] = 2'(m_stage[k]);
        return w;
    endfunction

    task automatic m_reset();
        for (int k = 0; k < N; k++) m_stage[k] = 3;
        m_slot = 0; m_calc = 8'hFF; m_valid = 0; m_err = 0;
    endtask

    task automatic m_clear();
        for (int k = 0; k < N; k++) m_stage[k] = 3;
        m_slot = 0; m_err = 0;
    endtask

    task automatic m_load(input logic [1:0] c);
        if (c == 2'b00) begin
            m_err = 1;
        end else begin
            if (m_valid && m_slot == 0)
                for (int k = 0; k < N; k++) m_stage[k] = 3;
            m_stage[m_slot] = int'(c);
            if (m_slot == N - 1) begin
                m_calc  = m_pack();
                m_valid = 1;
                m_slot  = 0;
            end else begin
                m_slot++;
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input int eslot, input logic [7:0] estage,
                           input logic [7:0] ecalc, input bit evalid, input bit eerr);
        chk({nm, ".slot"},  32'(bus.slot), 32'(eslot));
        chk({nm, ".stage"}, 32'(bus.stage_word), 32'(estage));
        chk({nm, ".calc"},  32'(bus.calc_word), 32'(ecalc));
        chk({nm, ".valid"}, 32'(bus.word_valid), 32'(evalid));
        chk({nm, ".err"},   32'(bus.err), 32'(eerr));
    endtask

    // Full strobe transaction with legal setup/hold and spacing.
    task automatic strobe(input logic [1:0] c, input int hold, input int low);
        @(posedge clk); #1 bus.trit_in = c;
        repeat (S + 1) @(posedge clk);
        #1 bus.trit_stb = 1'b1;
        repeat (hold) @(posedge clk);
        #1 bus.trit_stb = 1'b0;
        repeat (low) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1 bus.clr = 1'b1;
        @(posedge clk); #1 bus.clr = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] c;
        int         s0;

        bus.trit_in = 2'b11; bus.trit_stb = 1'b0; bus.clr = 1'b0;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all("reset", 0, 8'hFF, 8'hFF, 0, 0);
        @(posedge clk); #1 rst = 1'b0;

        // Vector table: legal entry, illegal code, clr, re-entry.
        tbl.push_back('{0, 2'b01, 1, 8'hFD, 8'hFF, 0, 0});
        tbl.push_back('{0, 2'b11, 2, 8'hFD, 8'hFF, 0, 0});
        tbl.push_back('{0, 2'b10, 3, 8'hED, 8'hFF, 0, 0});
        tbl.push_back('{0, 2'b01, 0, 8'h6D, 8'h6D, 1, 0});
        tbl.push_back('{0, 2'b01, 1, 8'hFD, 8'h6D, 1, 0});
        tbl.push_back('{0, 2'b00, 1, 8'hFD, 8'h6D, 1, 1});
        tbl.push_back('{0, 2'b10, 2, 8'hF9, 8'h6D, 1, 1});
        tbl.push_back('{1, 2'b11, 0, 8'hFF, 8'h6D, 1, 0});
        tbl.push_back('{0, 2'b01, 1, 8'hFD, 8'h6D, 1, 0});
        tbl.push_back('{0, 2'b01, 2, 8'hF5, 8'h6D, 1, 0});
        tbl.push_back('{0, 2'b01, 3, 8'hD5, 8'h6D, 1, 0});
        tbl.push_back('{0, 2'b01, 0, 8'h55, 8'h55, 1, 0});
        tbl.push_back('{0, 2'b10, 1, 8'hFE, 8'h55, 1, 0});
        tbl.push_back('{0, 2'b10, 2, 8'hFA, 8'h55, 1, 0});
        tbl.push_back('{0, 2'b10, 3, 8'hEA, 8'h55, 1, 0});
        tbl.push_back('{0, 2'b10, 0, 8'hAA, 8'hAA, 1, 0});
        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].do_clr) pulse_clr();
            else strobe(tbl[i].code, 4, 4);
            chk_all($sformatf("vec%0d", i), tbl[i].eslot, tbl[i].estage,
                    tbl[i].ecalc, tbl[i].evalid, tbl[i].eerr);
        end

        // clr in the exact accept cycle at slot 2.
        strobe(2'b01, 4, 4);
        strobe(2'b01, 4, 4);
        chk_all("coll_pre", 2, 8'hF5, 8'hAA, 1, 0);
        @(posedge clk); #1 bus.trit_in = 2'b10;
        repeat (S + 1) @(posedge clk);
        #1 bus.trit_stb = 1'b1;
        @(posedge clk);             // strobe captured
        @(posedge clk); #1 bus.clr = 1'b1;
        @(posedge clk); #1 bus.clr = 1'b0;
        repeat (3) @(posedge clk);
        #1 bus.trit_stb = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk_all("collide", 0, 8'hFF, 8'hAA, 1, 0);

        // Strobe held high with noisy trit_in, then a one-cycle low glitch.
        @(posedge clk); #1 bus.trit_in = 2'b10;
        repeat (S + 1) @(posedge clk);
        #1 bus.trit_stb = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            if (i >= S + 2) #1 bus.trit_in = 2'($urandom_range(0, 3));
        end
        @(negedge clk);
        chk_all("held", 1, 8'hFE, 8'hAA, 1, 0);
        @(posedge clk); #1 bus.trit_in = 2'b01;
        repeat (S + 1) @(posedge clk);
        #1 bus.trit_stb = 1'b0;
        @(posedge clk); #1 bus.trit_stb = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        s0 = int'(bus.slot);
        chk("glitch_slot_ok", 32'(s0 == 1 || s0 == 2), 32'd1);
        chk("glitch_stage", 32'(bus.stage_word), (s0 == 2) ? 32'hF6 : 32'hFE);
        chk("glitch_err", 32'(bus.err), 32'd0);
        @(posedge clk); #1 bus.trit_stb = 1'b0;
        repeat (4) @(posedge clk);

        // Asynchronous reset with slot 3 and a valid word.
        for (int i = 0; i < 3 && bus.slot != 3; i++) strobe(2'b01, 4, 4);
        chk("pre_rst_slot", 32'(bus.slot), 32'd3);
        @(posedge clk); #3 rst = 1'b1;
        #1 chk_all("async_rst", 0, 8'hFF, 8'hFF, 0, 0);
        @(posedge clk); #1 rst = 1'b0;

        // First strobe after release, cycle-exact latency.
        @(posedge clk); #1 bus.trit_in = 2'b10;
        repeat (S + 1) @(posedge clk);
        #1 bus.trit_stb = 1'b1;
        @(posedge clk);             // capture edge E
        @(posedge clk);             // E+1
        @(negedge clk);
        chk("lat_early_slot", 32'(bus.slot), 32'd0);
        @(posedge clk);             // E+2: update
        @(negedge clk);
        chk_all("lat_update", 1, 8'hFE, 8'hFF, 0, 0);
        @(posedge clk); #1 bus.trit_stb = 1'b0;
        repeat (4) @(posedge clk);

        // Randomized strobes and clears against the model.
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        m_reset();
        for (int i = 0; i < 120; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                pulse_clr();
                m_clear();
            end else begin
                c = 2'($urandom_range(0, 3));
                if (c == 2'b00 && $urandom_range(0, 1) == 0) c = 2'b01;
                strobe(c, S + 1 + int'($urandom_range(0, 3)), S + 1 + int'($urandom_range(0, 3)));
                m_load(c);
            end
            chk_all($sformatf("rnd%0d", i), m_slot, m_pack(), m_calc, m_valid, m_err);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
